test_pattern_gen_anim: RTL and testbench
========================================

Name: test_pattern_gen_anim

Overview:
Parametrised, animated successor to the static VGA test-pattern generator. It recovers column and row position from incoming HSync/VSync and selects one of eight patterns per frame. Patterns include a programmable solid colour, a sized checkerboard, colour bars, a grey ramp, a border, a bouncing box and scrolling bars. It sits between the sync-pulse generator and the porch/DAC output stage.

Parameters:
VIDEO_WIDTH, 3, bits per colour channel
TOTAL_COLS, 800, columns per line including blanking
TOTAL_ROWS, 525, rows per frame including blanking
ACTIVE_COLS, 640, visible columns; must be a multiple of 8
ACTIVE_ROWS, 480, visible rows
CHECK_LOG2, 5, checker square side is 2^CHECK_LOG2 pixels
BORDER_W, 2, border thickness in pixels
BOX_SIZE, 32, bouncing-box side in pixels
BOX_STEP, 2, box motion in pixels per frame, per axis
SCROLL_STEP, 4, bar scroll in columns per frame; must be < ACTIVE_COLS
RAMP_SHIFT, 4, ramp value = col >> RAMP_SHIFT, truncated to VIDEO_WIDTH

Ports:
i_Clk  in  1  pixel clock
i_Reset  in  1  asynchronous, active-high reset
i_Pattern  in  4  pattern select; sampled only at frame start
i_Color  in  3*VIDEO_WIDTH  {R,G,B} colour for pattern 1
i_HSync  in  1  horizontal sync in
i_VSync  in  1  vertical sync in
o_HSync  out  1  i_HSync delayed to align with video
o_VSync  out  1  i_VSync delayed to align with video
o_Red_Video  out  VIDEO_WIDTH  red
o_Grn_Video  out  VIDEO_WIDTH  green
o_Blu_Video  out  VIDEO_WIDTH  blue
o_Frame_Start  out  1  one-cycle pulse, aligned with outputs, marking frame start
o_Frame_Count  out  16  frames since reset; wraps at 2^16

Behaviour:
- Reset (async assert, sync release): all outputs 0; col, row, frame count, scroll, box X/Y = 0; box direction right/down; latched pattern = 0.
- Frame start is the rising edge of i_VSync, detected against a one-cycle-delayed copy.
- Position counters, stage 1:
  - On frame start: col <= 0, row <= 0.
  - Otherwise col increments, wrapping from TOTAL_COLS-1 to 0.
  - row increments on col wrap, wrapping from TOTAL_ROWS-1 to 0.
  - Counter width = $clog2 of the respective total.
- Per-frame updates, on frame start only:
  - Latch i_Pattern.
  - Frame count += 1.
  - scroll += SCROLL_STEP; subtract ACTIVE_COLS if the result is >= ACTIVE_COLS.
  - Box X: if moving right and X+BOX_STEP >= ACTIVE_COLS-BOX_SIZE, then X <= ACTIVE_COLS-BOX_SIZE and direction becomes left. If moving left and X <= BOX_STEP, then X <= 0 and direction becomes right. Otherwise step by BOX_STEP. Box Y follows the same rule with ACTIVE_ROWS.
- Pixel stage, stage 2 registered: output colour is black whenever col >= ACTIVE_COLS or row >= ACTIVE_ROWS, for every pattern. Full-scale value F = all ones. Active-region patterns:
  - 0: black.
  - 1: i_Color, applied live (not latched per frame).
  - 2: white where col[CHECK_LOG2] XOR row[CHECK_LOG2] is 1, else black.
  - 3: colour bars. Bar index b = col / (ACTIVE_COLS/8), range 0..7. R = b[2], G = b[1], B = b[0], each expanded to F.
  - 4: grey ramp; R = G = B = (col >> RAMP_SHIFT) truncated.
  - 5: white when row < BORDER_W, row >= ACTIVE_ROWS-BORDER_W, col < BORDER_W or col >= ACTIVE_COLS-BORDER_W; else black.
  - 6: white inside box (X <= col < X+BOX_SIZE and Y <= row < Y+BOX_SIZE); else blue F.
  - 7: as pattern 3, but using (col + scroll) mod ACTIVE_COLS.
  - 8..15: black.
- Latency: o_HSync, o_VSync and o_Frame_Start are exactly 2 cycles after the i_HSync/i_VSync edge and aligned with the video of the same pixel.
- A pattern change mid-frame takes effect only at the next frame start. Frame start coinciding with col wrap: the frame start wins.
- Reset mid-frame: outputs go 0 immediately. Counters free-run from 0 until the next VSync rising edge realigns them.

Decomposition:
- Shared package vga_pattern_pkg: pattern code constants (PAT_OFF, PAT_SOLID, PAT_CHECK, PAT_BARS, PAT_RAMP, PAT_BORDER, PAT_BOX, PAT_SCROLL) and the 8-entry bar-colour lookup function.
- One sub-module, sync_to_position: sync edge detect, col/row counters, frame-start pulse, sync delay. The parent holds the per-frame animation state and the pixel mux.

Test Plan:
- Reset, then VGA timing with i_Pattern=3 -> col 0..79 black, 80..159 blue (B=7), 560..639 white; col 640..799 all zero; sync latency = 2 cycles.
- i_Pattern=1, i_Color={3'd5,3'd2,3'd7} -> every active pixel R=5, G=2, B=7; blanking zero.
- i_Pattern switched 3->2 at row 100 -> bars continue to frame end; checker from the next frame. Pixel (32,0) is white, (32,32) is black.
- i_Pattern=6 for 310 frames -> box X: 0, 2, … 606, 608, then 606; Y reverses at 448. Box never exceeds the active area.
- i_Pattern=7 for 161 frames -> scroll 4, 8, … 636, then 0 at frame 160. Col 0 colour matches bar index (scroll/80).
- i_Reset asserted mid-line at frame 5 -> all outputs 0 within the same cycle. o_Frame_Count = 0, then 1 after the next VSync rise.

Source files
------------

// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the animated test-pattern generator: pattern codes,
// per-axis bounce state and the colour-bar lookup.
package vga_pattern_pkg;

    typedef enum logic [3:0] {
        PAT_OFF    = 4'd0,
        PAT_SOLID  = 4'd1,
        PAT_CHECK  = 4'd2,
        PAT_BARS   = 4'd3,
        PAT_RAMP   = 4'd4,
        PAT_BORDER = 4'd5,
        PAT_BOX    = 4'd6,
        PAT_SCROLL = 4'd7
    } pattern_e;

    typedef struct packed {
        logic [15:0] pos;
        logic        back;   // 1 = moving left / up
    } axis_t;

    // Returns {R,G,B} on/off flags; bars run black, blue, green, cyan, red, magenta, yellow, white.
    function automatic logic [2:0] bar_color(input logic [2:0] bar);
        logic [2:0] rgb;
        case (bar)
            3'd0:    rgb = 3'b000;
            3'd1:    rgb = 3'b001;
            3'd2:    rgb = 3'b010;
            3'd3:    rgb = 3'b011;
            3'd4:    rgb = 3'b100;
            3'd5:    rgb = 3'b101;
            3'd6:    rgb = 3'b110;
            default: rgb = 3'b111;
        endcase
        return rgb;
    endfunction

    function automatic axis_t bounce_step(input axis_t cur, input int step, input int limit);
        axis_t nxt;
        nxt = cur;
        if (!cur.back) begin
            if (int'(cur.pos) + step >= limit) begin
                nxt.pos  = 16'(limit);
                nxt.back = 1'b1;
            end else begin
                nxt.pos = cur.pos + 16'(step);
            end
        end else if (int'(cur.pos) <= step) begin
            nxt.pos  = '0;
            nxt.back = 1'b0;
        end else begin
            nxt.pos = cur.pos - 16'(step);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_to_position.sv
// Recovers column/row from the incoming syncs and forms the first pipeline stage:
// delayed syncs, frame-start pulse and position counters.
module sync_to_position #(
    parameter int TOTAL_COLS = 800,
    parameter int TOTAL_ROWS = 525,
    localparam int COL_W = $clog2(TOTAL_COLS),
    localparam int ROW_W = $clog2(TOTAL_ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    output logic             frame_start,
    output logic             hsync_dly,
    output logic             vsync_dly,
    output logic             frame_start_dly,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row
);

    assign frame_start = vsync & ~vsync_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_dly       <= 1'b0;
            vsync_dly       <= 1'b0;
            frame_start_dly <= 1'b0;
            col             <= '0;
            row             <= '0;
        end else begin
            hsync_dly       <= hsync;
            vsync_dly       <= vsync;
            frame_start_dly <= frame_start;
            // frame start has priority over the normal column wrap
            if (frame_start) begin
                col <= '0;
                row <= '0;
            end else if (col == COL_W'(TOTAL_COLS - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(TOTAL_ROWS - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/test_pattern_gen_anim.sv
// Animated VGA test-pattern generator: per-frame animation state plus the
// registered pixel mux, two cycles behind the incoming syncs.
module test_pattern_gen_anim
    import vga_pattern_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int CHECK_LOG2  = 5,
    parameter int BORDER_W    = 2,
    parameter int BOX_SIZE    = 32,
    parameter int BOX_STEP    = 2,
    parameter int SCROLL_STEP = 4,
    parameter int RAMP_SHIFT  = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic [3:0]               i_Pattern,
    input  logic [3*VIDEO_WIDTH-1:0] i_Color,
    input  logic                     i_HSync,
    input  logic                     i_VSync,
    output logic                     o_HSync,
    output logic                     o_VSync,
    output logic [VIDEO_WIDTH-1:0]   o_Red_Video,
    output logic [VIDEO_WIDTH-1:0]   o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0]   o_Blu_Video,
    output logic                     o_Frame_Start,
    output logic [15:0]              o_Frame_Count
);

    localparam int COL_W     = $clog2(TOTAL_COLS);
    localparam int ROW_W     = $clog2(TOTAL_ROWS);
    localparam int RGB_W     = 3 * VIDEO_WIDTH;
    localparam int BAR_W     = ACTIVE_COLS / 8;
    localparam int BOX_X_MAX = ACTIVE_COLS - BOX_SIZE;
    localparam int BOX_Y_MAX = ACTIVE_ROWS - BOX_SIZE;

    logic             frame_start, hsync_s1, vsync_s1, frame_start_s1;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    sync_to_position #(
        .TOTAL_COLS(TOTAL_COLS),
        .TOTAL_ROWS(TOTAL_ROWS)
    ) u_sync (
        .clk            (i_Clk),
        .rst            (i_Reset),
        .hsync          (i_HSync),
        .vsync          (i_VSync),
        .frame_start    (frame_start),
        .hsync_dly      (hsync_s1),
        .vsync_dly      (vsync_s1),
        .frame_start_dly(frame_start_s1),
        .col            (col),
        .row            (row)
    );

    logic [3:0]       pattern_q;
    logic [15:0]      frame_count;
    logic [COL_W-1:0] scroll;
    axis_t            box_x, box_y;
    logic [RGB_W-1:0] color_s1;

    // Animation state advances on the same edge that zeroes the counters, so
    // the first pixel of a frame already sees the new positions.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            pattern_q   <= '0;
            frame_count <= '0;
            scroll      <= '0;
            box_x       <= '0;
            box_y       <= '0;
            color_s1    <= '0;
        end else begin
            color_s1 <= i_Color;
            if (frame_start) begin
                pattern_q   <= i_Pattern;
                frame_count <= frame_count + 16'd1;
                if (int'(scroll) + SCROLL_STEP >= ACTIVE_COLS)
                    scroll <= COL_W'(int'(scroll) + SCROLL_STEP - ACTIVE_COLS);
                else
                    scroll <= scroll + COL_W'(SCROLL_STEP);
                box_x <= bounce_step(box_x, BOX_STEP, BOX_X_MAX);
                box_y <= bounce_step(box_y, BOX_STEP, BOX_Y_MAX);
            end
        end
    end

    function automatic logic [RGB_W-1:0] expand(input logic [2:0] c);
        return {{VIDEO_WIDTH{c[2]}}, {VIDEO_WIDTH{c[1]}}, {VIDEO_WIDTH{c[0]}}};
    endfunction

    logic [RGB_W-1:0]       rgb;
    logic [VIDEO_WIDTH-1:0] ramp;
    logic [2:0]             bar_idx, scroll_idx;
    int                     col_i, row_i, scrolled, bx, by;

    always_comb begin
        col_i    = int'(col);
        row_i    = int'(row);
        bx       = int'(box_x.pos);
        by       = int'(box_y.pos);
        scrolled = col_i + int'(scroll);
        if (scrolled >= ACTIVE_COLS)
            scrolled = scrolled - ACTIVE_COLS;
        bar_idx    = 3'(col_i / BAR_W);
        scroll_idx = 3'(scrolled / BAR_W);
        ramp       = VIDEO_WIDTH'(col >> RAMP_SHIFT);
        rgb        = '0;
        case (pattern_q)
            PAT_SOLID:  rgb = color_s1;
            PAT_CHECK:  if (col[CHECK_LOG2] ^ row[CHECK_LOG2]) rgb = '1;
            PAT_BARS:   rgb = expand(bar_color(bar_idx));
            PAT_RAMP:   rgb = {3{ramp}};
            PAT_BORDER: if (row_i < BORDER_W || row_i >= ACTIVE_ROWS - BORDER_W ||
                            col_i < BORDER_W || col_i >= ACTIVE_COLS - BORDER_W) rgb = '1;
            PAT_BOX:    rgb = (col_i >= bx && col_i < bx + BOX_SIZE &&
                               row_i >= by && row_i < by + BOX_SIZE) ? '1 : expand(3'b001);
            PAT_SCROLL: rgb = expand(bar_color(scroll_idx));
            default:    rgb = '0;
        endcase
        if (col_i >= ACTIVE_COLS || row_i >= ACTIVE_ROWS)
            rgb = '0;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
        end else begin
            o_HSync       <= hsync_s1;
            o_VSync       <= vsync_s1;
            o_Frame_Start <= frame_start_s1;
            {o_Red_Video, o_Grn_Video, o_Blu_Video} <= rgb;
        end
    end

    assign o_Frame_Count = frame_count;

endmodule

// File: tb/tb_test_pattern_gen_anim.sv
// Scoreboard bench for test_pattern_gen_anim on a shrunken raster (40x20, 32x16 active)
// so many animated frames fit in a short run.
module tb_test_pattern_gen_anim;

    localparam int VW  = 3;
    localparam int TC  = 40;
    localparam int TR  = 20;
    localparam int AC  = 32;
    localparam int AR  = 16;
    localparam int CL  = 2;
    localparam int BDW = 2;
    localparam int BS  = 8;
    localparam int BST = 2;
    localparam int SS  = 4;
    localparam int RS  = 2;
    localparam int FC  = TC * TR;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic [3:0]    pat   = 4'd3;
    logic [8:0]    color = 9'o000;
    logic          hs    = 1'b0;
    logic          vs    = 1'b0;
    logic          o_hs, o_vs, o_fs;
    logic [VW-1:0] o_r, o_g, o_b;
    logic [15:0]   o_fc;

    always #5 clk = ~clk;

    test_pattern_gen_anim #(
        .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
        .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .CHECK_LOG2(CL),
        .BORDER_W(BDW), .BOX_SIZE(BS), .BOX_STEP(BST),
        .SCROLL_STEP(SS), .RAMP_SHIFT(RS)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Pattern    (pat),
        .i_Color      (color),
        .i_HSync      (hs),
        .i_VSync      (vs),
        .o_HSync      (o_hs),
        .o_VSync      (o_vs),
        .o_Red_Video  (o_r),
        .o_Grn_Video  (o_g),
        .o_Blu_Video  (o_b),
        .o_Frame_Start(o_fs),
        .o_Frame_Count(o_fc)
    );

    typedef struct {
        logic [11:0] v;
        int          c;
        int          r;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    // Hand-derived {R,G,B} per bar index, 3 bits per channel in octal.
    logic [8:0] bar_rgb [0:7] = '{9'o000, 9'o007, 9'o070, 9'o077, 9'o700, 9'o707, 9'o770, 9'o777};

    int m_pat = 0, m_scroll = 0, m_bx = 0, m_by = 0;
    bit m_bl = 1'b0, m_bu = 1'b0, m_pvs = 1'b0;
    int bc = 0, br = 0;

    function automatic logic [8:0] exp_pix(input int c, input int r);
        int         sc;
        logic [2:0] ramp;
        if (c >= AC || r >= AR) return 9'o000;
        sc   = (c + m_scroll) % AC;
        ramp = 3'(c >> RS);
        case (m_pat)
            1:       return color;
            2:       return ((((c >> CL) ^ (r >> CL)) & 1) != 0) ? 9'o777 : 9'o000;
            3:       return bar_rgb[c / (AC / 8)];
            4:       return {ramp, ramp, ramp};
            5:       return (r < BDW || r >= AR - BDW || c < BDW || c >= AC - BDW) ? 9'o777 : 9'o000;
            6:       return (c >= m_bx && c < m_bx + BS && r >= m_by && r < m_by + BS) ? 9'o777 : 9'o007;
            7:       return bar_rgb[sc / (AC / 8)];
            default: return 9'o000;
        endcase
    endfunction

    task automatic bounce(inout int p, inout bit back, input int lim);
        if (!back) begin
            if (p + BST >= lim) begin p = lim; back = 1'b1; end
            else p = p + BST;
        end else if (p <= BST) begin
            p = 0; back = 1'b0;
        end else begin
            p = p - BST;
        end
    endtask

    task automatic model_reset();
        m_pat = 0; m_scroll = 0; m_bx = 0; m_by = 0;
        m_bl = 1'b0; m_bu = 1'b0; m_pvs = 1'b0;
    endtask

    // Drive one raster position and queue the response expected two edges later.
    task automatic apply_cycle();
        exp_t e;
        bit   fs;
        hs = (bc >= AC + 2 && bc < AC + 6);
        vs = (br < 2);
        fs = vs && !m_pvs;
        m_pvs = vs;
        if (fs) begin
            m_pat    = int'(pat);
            m_scroll = m_scroll + SS;
            if (m_scroll >= AC) m_scroll = m_scroll - AC;
            bounce(m_bx, m_bl, AC - BS);
            bounce(m_by, m_bu, AR - BS);
        end
        e.v = {hs, vs, fs, exp_pix(bc, br)};
        e.c = bc;
        e.r = br;
        sb_q.push_back(e);
        bc++;
        if (bc == TC) begin
            bc = 0;
            br = (br == TR - 1) ? 0 : br + 1;
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            apply_cycle();
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int all_outs();
        return int'({o_hs, o_vs, o_fs, o_r, o_g, o_b, o_fc});
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (mon_en && sb_q.size() > 2) begin
                e   = sb_q.pop_front();
                act = {o_hs, o_vs, o_fs, o_r, o_g, o_b};
                n_vec++;
                if (act !== e.v) begin
                    n_err++;
                    $display("FAIL pixel(%0d,%0d): got sync=%b rgb=%o want sync=%b rgb=%o",
                             e.c, e.r, act[11:9], act[8:0], e.v[11:9], e.v[8:0]);
                end
            end
        end
    end

    initial begin : stim
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_val("reset_outputs", all_outs(), 0);

        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        apply_cycle();
        run_cycles(2 * FC - 1);                       // frames 1-2: colour bars
        check_val("frame_count_2", int'(o_fc), 2);

        pat = 4'd1; color = 9'o527;                   // frame 3: solid R=5 G=2 B=7
        run_cycles(FC);
        pat = 4'd3;                                   // frame 4: bars, switch to checker at row 5
        run_cycles(5 * TC);
        pat = 4'd2;
        run_cycles(FC - 5 * TC);
        run_cycles(FC);                               // frame 5: checker
        check_val("frame_count_5", int'(o_fc), 5);

        pat = 4'd4; run_cycles(FC);                   // ramp
        pat = 4'd5; run_cycles(FC);                   // border
        pat = 4'd6; run_cycles(14 * FC);              // box bounces on both axes
        pat = 4'd7; run_cycles(9 * FC);               // scroll wraps back to 0
        pat = 4'd9; run_cycles(FC);                   // undefined code -> black
        check_val("frame_count_31", int'(o_fc), 31);

        pat = 4'd3;
        run_cycles(5 * TC + 10);
        #2 rst = 1'b1;
        #1 check_val("midframe_reset_outputs", all_outs(), 0);
        mon_en = 1'b0;
        sb_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        apply_cycle();
        run_cycles(FC - (5 * TC + 10) - 1);
        check_val("frame_count_before_vsync", int'(o_fc), 0);
        run_cycles(2 * TC);
        check_val("frame_count_after_vsync", int'(o_fc), 1);
        run_cycles(FC);
        run_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
